// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - parametrised UART transmitter with ready/valid input FIFO
// Optional parity bit: define UART_TX_PARITY_EN.
module uart_tx_fifo #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 9600,
   parameter int DATA_W     = 8,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4,
   parameter int PARITY_ODD = 0
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            tx_valid,
   input  logic [DATA_W-1:0]               tx_data,
   output logic                            tx_ready,
   output logic                            tx,
   output logic                            tx_busy,
   output logic                            tx_done,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);
   localparam int DIVISOR = CLK_FREQ / BAUD;
   localparam int CW      = $clog2(DIVISOR);
   localparam int LW      = $clog2(FIFO_DEPTH + 1);
   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int BW      = $clog2(DATA_W);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t              state_q;
   logic [CW-1:0]       baud_q;
   logic [BW-1:0]       bit_q;
   logic [DATA_W-1:0]   shift_q;
   logic                tx_q;
   logic                done_q;
   logic                rdy_q;
   logic [DATA_W-1:0]   mem [FIFO_DEPTH];
   logic [AW-1:0]       wr_q, rd_q;
   logic [LW-1:0]       count_q, count_d;
   logic                empty, full, push, pop;
   logic                baud_last, data_last, stop_last;
   logic [DATA_W-1:0]   head;
`ifdef UART_TX_PARITY_EN
   logic                par_q;
   logic                par_head;
   assign par_head = (PARITY_ODD != 0) ? ~^head : ^head;
`endif

   assign empty     = (count_q == '0);
   assign full      = (count_q == LW'(FIFO_DEPTH));
   assign head      = mem[rd_q];
   assign baud_last = (baud_q == CW'(DIVISOR - 1));
   assign data_last = (bit_q == BW'(DATA_W - 1));
   assign stop_last = (bit_q == BW'(STOP_BITS - 1));
   assign push      = tx_valid && !full;
   // IDLE waits one cycle of visible occupancy before popping; STOP chains frames with no gap.
   assign pop       = !empty && (((state_q == S_IDLE) && rdy_q) ||
                                 ((state_q == S_STOP) && baud_last && stop_last));

   assign tx_ready   = !full;
   assign tx         = tx_q;
   assign tx_done    = done_q;
   assign tx_busy    = (state_q != S_IDLE) || !empty;
   assign fifo_level = count_q;

   always_comb begin
      count_d = count_q;
      if (push && !pop)
         count_d = count_q + LW'(1);
      else if (pop && !push)
         count_d = count_q - LW'(1);
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_q] <= tx_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         rdy_q   <= 1'b0;
      end else begin
         if (push)
            wr_q <= wr_q + AW'(1);
         if (pop)
            rd_q <= rd_q + AW'(1);
         count_q <= count_d;
         rdy_q   <= !empty;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               tx_q <= 1'b1;
               if (pop) begin
                  shift_q <= head;
`ifdef UART_TX_PARITY_EN
                  par_q   <= par_head;
`endif
                  baud_q  <= '0;
                  tx_q    <= 1'b0;
                  state_q <= S_START;
               end
            end
            S_START: begin
               if (baud_last) begin
                  baud_q  <= '0;
                  tx_q    <= shift_q[0];
                  state_q <= S_DATA;
               end else
                  baud_q <= baud_q + CW'(1);
            end
            S_DATA: begin
               if (baud_last) begin
                  baud_q <= '0;
                  if (data_last) begin
                     bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
                     tx_q    <= par_q;
                     state_q <= S_PARITY;
`else
                     tx_q    <= 1'b1;
                     state_q <= S_STOP;
`endif
                  end else begin
                     bit_q   <= bit_q + BW'(1);
                     shift_q <= shift_q >> 1;
                     tx_q    <= shift_q[1];
                  end
               end else
                  baud_q <= baud_q + CW'(1);
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (baud_last) begin
                  baud_q  <= '0;
                  tx_q    <= 1'b1;
                  state_q <= S_STOP;
               end else
                  baud_q <= baud_q + CW'(1);
            end
`endif
            S_STOP: begin
               done_q <= stop_last && (baud_q == CW'(DIVISOR - 2));
               if (baud_last) begin
                  baud_q <= '0;
                  if (stop_last) begin
                     bit_q <= '0;
                     if (pop) begin
                        shift_q <= head;
`ifdef UART_TX_PARITY_EN
                        par_q   <= par_head;
`endif
                        tx_q    <= 1'b0;
                        state_q <= S_START;
                     end else
                        state_q <= S_IDLE;
                  end else
                     bit_q <= bit_q + BW'(1);
               end else
                  baud_q <= baud_q + CW'(1);
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule
